updown_count_monitor: RTL and testbench

Receive-side companion to the team's 4-bit up/down counter. It samples the counter's output bus, infers the count direction, and locks onto the stream. It then flags illegal steps and reports wrap-around events. It sits downstream of any up/down counter instance, as a run-time checker and direction recoverer.

---
 rtl/updown_pkg.sv | 34 +++
 rtl/updown_step_classifier.sv | 41 ++++
 rtl/updown_count_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_updown_count_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// -----------------------------------------------------------------------------
// updown_pkg
// Shared types and constants for up/down counter checkers.
//   state_e : monitor lock state (UNLOCKED, ACQUIRE, LOCKED, ERROR)
//   step_e  : classification of one observed counter step
//   DIR_UP / DIR_DOWN : direction encoding, identical to the counter's flag
// -----------------------------------------------------------------------------
package updown_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    STEP_UP,
    STEP_DOWN,
    STEP_HOLD,
    STEP_JUMP
  } step_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Width of the run/miss counters; holds LOCK_STEPS and ERR_LIMIT up to 15.
  localparam int RUN_W = 4;

  function automatic logic step_is_legal(input step_e s);
    return (s == STEP_UP) || (s == STEP_DOWN);
  endfunction

endpackage

// File: rtl/updown_step_classifier.sv
// -----------------------------------------------------------------------------
// updown_step_classifier
// Combinational classification of one counter step (count_i relative to
// prev_i), using WIDTH-bit modulo arithmetic.
// Ports:
//   prev_i  [WIDTH-1:0] : previously accepted sample
//   count_i [WIDTH-1:0] : current sample
//   step_o  step_e      : STEP_UP / STEP_DOWN / STEP_HOLD / STEP_JUMP
//   wrap_o              : legal step that crosses the wrap boundary
// -----------------------------------------------------------------------------
module updown_step_classifier
  import updown_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] count_i,
  output step_e            step_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] delta;

  assign delta = count_i - prev_i;

  always_comb begin
    step_o = STEP_JUMP;
    if (delta == WIDTH'(1)) begin
      step_o = STEP_UP;
    end else if (delta == '1) begin
      step_o = STEP_DOWN;
    end else if (delta == '0) begin
      step_o = STEP_HOLD;
    end
  end

  // Up wraps all-ones -> 0, down wraps 0 -> all-ones.
  assign wrap_o = ((step_o == STEP_UP)   && (prev_i == '1)) ||
                  ((step_o == STEP_DOWN) && (prev_i == '0));

endmodule

// File: rtl/updown_count_monitor.sv
// -----------------------------------------------------------------------------
// updown_count_monitor
// Observes an up/down counter bus, recovers its direction, locks onto it,
// flags illegal steps and counts wrap-around events.
// Ports:
//   clk, reset (async, active low)
//   sample_valid, count_in [WIDTH-1:0] : sampled counter stream
//   clear_err                          : leave ERROR, clear err_count
//   locked, err_state                  : state decode
//   dir                                : recovered direction (0 up, 1 down)
//   step_err, wrap_pulse               : one-cycle event pulses
//   wrap_count, err_count [CNT_W-1:0]  : saturating event counters
//   restart_pulse                      : only with RESTART_DETECT_EN defined
// Optional feature macro: RESTART_DETECT_EN (a jump/hold to the counter's
// reset value while locked is treated as a legitimate restart).
// -----------------------------------------------------------------------------
module updown_count_monitor
  import updown_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 3,
  parameter int ERR_LIMIT  = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             dir,
  output logic             step_err,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_state
`ifdef RESTART_DETECT_EN
  ,
  output logic             restart_pulse
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] miss_q, miss_d;
  logic             dir_q, dir_d;
  logic             cand_q, cand_d;
  logic             step_err_q, step_err_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             restart_q, restart_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  step_e            step;
  logic             wrap;
  logic             legal;
  logic             step_dir;
  logic [RUN_W-1:0] miss_inc;

  updown_step_classifier #(.WIDTH(WIDTH)) u_classifier (
    .prev_i  (prev_q),
    .count_i (count_in),
    .step_o  (step),
    .wrap_o  (wrap)
  );

  // Without a valid previous sample there is no step to judge.
  assign legal    = prev_valid_q && step_is_legal(step);
  assign step_dir = (step == STEP_DOWN) ? DIR_DOWN : DIR_UP;
  assign miss_inc = miss_q + RUN_W'(1);

`ifdef RESTART_DETECT_EN
  logic [WIDTH-1:0] restart_val;
  assign restart_val = (dir_q == DIR_DOWN) ? '1 : '0;
`endif

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    run_d        = run_q;
    miss_d       = miss_q;
    dir_d        = dir_q;
    cand_d       = cand_q;
    step_err_d   = 1'b0;
    wrap_pulse_d = 1'b0;
    restart_d    = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (sample_valid) begin
      prev_d = count_in;
      case (state_q)
        UNLOCKED: begin
          prev_valid_d = 1'b1;
          run_d        = '0;
          state_d      = ACQUIRE;
        end
        ACQUIRE: begin
          if (legal) begin
            if ((run_q == '0) || (step_dir != cand_q)) begin
              cand_d = step_dir;
              run_d  = RUN_W'(1);
            end else begin
              run_d = run_q + RUN_W'(1);
            end
            if (run_d == RUN_W'(LOCK_STEPS)) begin
              state_d = LOCKED;
              dir_d   = cand_d;
              miss_d  = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (legal && (step_dir == dir_q)) begin
            miss_d = '0;
            if (wrap) begin
              wrap_pulse_d = 1'b1;
              if (wrap_cnt_q != '1) begin
                wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
              end
            end
          end
`ifdef RESTART_DETECT_EN
          else if (!legal && (count_in == restart_val)) begin
            miss_d    = '0;
            restart_d = 1'b1;
          end
`endif
          else begin
            step_err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            miss_d = miss_inc;
            if (miss_inc == RUN_W'(ERR_LIMIT)) begin
              state_d = ERROR;
            end
          end
        end
        default: ; // ERROR: samples only refresh prev
      endcase
    end

    // clear_err acts in ERROR regardless of sample_valid.
    if ((state_q == ERROR) && clear_err) begin
      state_d      = UNLOCKED;
      prev_valid_d = 1'b0;
      run_d        = '0;
      err_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= UNLOCKED;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      run_q        <= '0;
      miss_q       <= '0;
      dir_q        <= DIR_UP;
      cand_q       <= DIR_UP;
      step_err_q   <= 1'b0;
      wrap_pulse_q <= 1'b0;
      restart_q    <= 1'b0;
      wrap_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      dir_q        <= dir_d;
      cand_q       <= cand_d;
      step_err_q   <= step_err_d;
      wrap_pulse_q <= wrap_pulse_d;
      restart_q    <= restart_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err_state  = (state_q == ERROR);
  assign dir        = dir_q;
  assign step_err   = step_err_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_cnt_q;
  assign err_count  = err_cnt_q;

`ifdef RESTART_DETECT_EN
  assign restart_pulse = restart_q;
`else
  logic unused_restart;
  assign unused_restart = restart_q;
`endif

endmodule

// File: tb/tb_updown_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_updown_count_monitor
// Directed bench for updown_count_monitor (WIDTH=4, LOCK_STEPS=3,
// ERR_LIMIT=2, CNT_W=8). Honours RESTART_DETECT_EN when defined.
// -----------------------------------------------------------------------------
module tb_updown_count_monitor;

  logic       clk;
  logic       reset;
  logic       sample_valid;
  logic [3:0] count_in;
  logic       clear_err;
  logic       locked;
  logic       dir;
  logic       step_err;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic [7:0] err_count;
  logic       err_state;
`ifdef RESTART_DETECT_EN
  logic       restart_pulse;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  updown_count_monitor #(
    .WIDTH(4), .LOCK_STEPS(3), .ERR_LIMIT(2), .CNT_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .count_in     (count_in),
    .clear_err    (clear_err),
    .locked       (locked),
    .dir          (dir),
    .step_err     (step_err),
    .wrap_pulse   (wrap_pulse),
    .wrap_count   (wrap_count),
    .err_count    (err_count),
    .err_state    (err_state)
`ifdef RESTART_DETECT_EN
    ,
    .restart_pulse(restart_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Present one cycle of inputs, let the edge take it, sample 1 ns later.
  task automatic step(input logic v, input logic [3:0] val, input logic clr);
    @(negedge clk);
    sample_valid = v;
    count_in     = val;
    clear_err    = clr;
    @(posedge clk);
    #1;
    $display("t=%0t valid=%0d count=%h clr=%0d -> locked=%0d dir=%0d serr=%0d wrap=%0d wcnt=%0d ecnt=%0d estate=%0d",
             $time, v, val, clr, locked, dir, step_err, wrap_pulse, wrap_count, err_count, err_state);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_valid = 1'b0;
    clear_err    = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b0;
    count_in     = 4'h0;
    clear_err    = 1'b0;
    #2;
    chk("rst_locked",   32'(locked),     32'd0);
    chk("rst_err_state",32'(err_state),  32'd0);
    chk("rst_wrap_cnt", 32'(wrap_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ---- 1: lock down, wrap, error, then asynchronous reset ----
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h1, 1'b0);
    chk("t1_not_locked_yet", 32'(locked), 32'd0);
    step(1'b1, 4'h0, 1'b0);
    chk("t1_locked_down", 32'(locked), 32'd1);
    chk("t1_dir_down",    32'(dir),    32'd1);
    step(1'b1, 4'hF, 1'b0);
    chk("t1_wrap_down",   32'(wrap_pulse), 32'd1);
    chk("t1_wrap_cnt",    32'(wrap_count), 32'd1);
    step(1'b1, 4'h7, 1'b0);
    chk("t1_step_err",    32'(step_err),  32'd1);
    chk("t1_err_cnt",     32'(err_count), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t1_async_locked",   32'(locked),     32'd0);
    chk("t1_async_dir",      32'(dir),        32'd0);
    chk("t1_async_step_err", 32'(step_err),   32'd0);
    chk("t1_async_wrap_cnt", 32'(wrap_count), 32'd0);
    chk("t1_async_err_cnt",  32'(err_count),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    chk("t1_relock_pending", 32'(locked), 32'd0);
    step(1'b1, 4'h6, 1'b0);
    chk("t1_relock_up", 32'(locked), 32'd1);
    chk("t1_dir_up",    32'(dir),    32'd0);

    // ---- 2: lock down, hold error, miss cleared by a good step ----
    do_reset();
    step(1'b1, 4'hD, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    step(1'b1, 4'hB, 1'b0);
    step(1'b1, 4'hA, 1'b0);
    chk("t2_locked", 32'(locked), 32'd1);
    chk("t2_dir",    32'(dir),    32'd1);
    step(1'b1, 4'h9, 1'b0);
    step(1'b1, 4'h8, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    chk("t2_no_err", 32'(step_err), 32'd0);
    step(1'b1, 4'h7, 1'b0);
    chk("t2_hold_err",    32'(step_err),  32'd1);
    chk("t2_err_cnt1",    32'(err_count), 32'd1);
    chk("t2_still_locked",32'(locked),    32'd1);
    step(1'b1, 4'h6, 1'b0);
    chk("t2_good_no_err", 32'(step_err), 32'd0);
    step(1'b1, 4'h6, 1'b0);
    chk("t2_err_again",   32'(step_err),  32'd1);
    chk("t2_err_cnt2",    32'(err_count), 32'd2);
    chk("t2_miss_cleared",32'(locked),    32'd1);
    step(1'b0, 4'h6, 1'b1);
    chk("t2_clear_ignored_lock", 32'(locked),    32'd1);
    chk("t2_clear_ignored_cnt",  32'(err_count), 32'd2);

    // ---- 3: up wrap F -> 0 ----
    do_reset();
    step(1'b1, 4'hB, 1'b0);
    step(1'b1, 4'hC, 1'b0);
    step(1'b1, 4'hD, 1'b0);
    step(1'b1, 4'hE, 1'b0);
    chk("t3_locked", 32'(locked), 32'd1);
    step(1'b1, 4'hF, 1'b0);
    chk("t3_no_wrap_F", 32'(wrap_pulse), 32'd0);
    step(1'b1, 4'h0, 1'b0);
    chk("t3_wrap",      32'(wrap_pulse), 32'd1);
    chk("t3_wrap_cnt",  32'(wrap_count), 32'd1);
    step(1'b1, 4'h1, 1'b0);
    chk("t3_wrap_one_cycle", 32'(wrap_pulse), 32'd0);

    // ---- 4: two jumps -> ERROR, then clear_err ----
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'h9, 1'b0);
    chk("t4_err1",     32'(step_err),  32'd1);
    chk("t4_err_cnt1", 32'(err_count), 32'd1);
    chk("t4_locked1",  32'(locked),    32'd1);
    step(1'b1, 4'h2, 1'b0);
    chk("t4_err2",      32'(step_err),  32'd1);
    chk("t4_err_cnt2",  32'(err_count), 32'd2);
    chk("t4_err_state", 32'(err_state), 32'd1);
    chk("t4_unlocked",  32'(locked),    32'd0);
    step(1'b0, 4'h0, 1'b0);
    chk("t4_idle_no_err", 32'(step_err),  32'd0);
    chk("t4_idle_state",  32'(err_state), 32'd1);
    step(1'b1, 4'h3, 1'b0);
    chk("t4_err_sample_no_err", 32'(step_err),  32'd0);
    chk("t4_err_sample_cnt",    32'(err_count), 32'd2);
    step(1'b0, 4'h0, 1'b1);
    chk("t4_cleared_state", 32'(err_state),  32'd0);
    chk("t4_cleared_lock",  32'(locked),     32'd0);
    chk("t4_cleared_cnt",   32'(err_count),  32'd0);
    chk("t4_wrap_kept",     32'(wrap_count), 32'd1);
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'h6, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    chk("t4_relock", 32'(locked), 32'd1);

    // ---- 5: sample_valid gaps ----
    do_reset();
    step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h1, 1'b0);
    step(1'b0, 4'h7, 1'b0);
    chk("t5_idle_serr", 32'(step_err),   32'd0);
    chk("t5_idle_wrap", 32'(wrap_pulse), 32'd0);
    step(1'b0, 4'h9, 1'b0);
    chk("t5_idle2_serr", 32'(step_err), 32'd0);
    step(1'b1, 4'h2, 1'b0);
    chk("t5_not_yet", 32'(locked), 32'd0);
    step(1'b1, 4'h3, 1'b0);
    chk("t5_locked", 32'(locked), 32'd1);
    chk("t5_dir",    32'(dir),    32'd0);

    // ---- 6: jump to the counter reset value while locked up ----
    do_reset();
    step(1'b1, 4'h6, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    step(1'b1, 4'h8, 1'b0);
    step(1'b1, 4'h9, 1'b0);
    chk("t6_locked", 32'(locked), 32'd1);
    step(1'b1, 4'h0, 1'b0);
`ifdef RESTART_DETECT_EN
    chk("t6_restart",      32'(restart_pulse), 32'd1);
    chk("t6_no_step_err",  32'(step_err),      32'd0);
    chk("t6_err_cnt",      32'(err_count),     32'd0);
`else
    chk("t6_step_err",     32'(step_err),      32'd1);
    chk("t6_err_cnt",      32'(err_count),     32'd1);
`endif
    chk("t6_still_locked", 32'(locked), 32'd1);
    step(1'b1, 4'h1, 1'b0);
    chk("t6_next_ok", 32'(step_err), 32'd0);
`ifdef RESTART_DETECT_EN
    chk("t6_restart_one_cycle", 32'(restart_pulse), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
